// File: rtl/ntt_intt_pwm_cg_pkg.sv
// ---------------------------------------------------------------------------
// ntt_intt_pwm_cg_pkg
//
// Shared definitions for the NTT/INTT/PWM clock-gate enable controller:
//   - cg_state_e        : controller state encoding (RUN / GATED / WAKE)
//   - IDLE_CYCLES_DEF   : default idle run length before gating
//   - WAKE_CYCLES_DEF   : default settle length spent in WAKE
//   - STATS_W           : width of the optional gated-cycle statistics counter
//                         (used only when NTT_INTT_PWM_CG_STATS_EN is defined)
// ---------------------------------------------------------------------------
package ntt_intt_pwm_cg_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        GATED = 2'b01,
        WAKE  = 2'b10
    } cg_state_e;

    localparam int IDLE_CYCLES_DEF = 16;
    localparam int WAKE_CYCLES_DEF = 2;
    localparam int STATS_W         = 32;

endpackage : ntt_intt_pwm_cg_pkg

// File: rtl/ntt_intt_pwm_clock_gate_ctrl.sv
// ---------------------------------------------------------------------------
// ntt_intt_pwm_clock_gate_ctrl
//
// Enable-side controller for the accelerator core clock gate. Runs on the
// free-running clock and drives the en_i pin of an integrator-supplied gate
// cell. After IDLE_CYCLES consecutive idle cycles in RUN the core clock is
// gated; a wake request (or any other activity) ungates it, and the request
// is acknowledged only after WAKE_CYCLES settle cycles.
//
// Ports:
//   clk_i          in   free-running clock
//   rst_i          in   synchronous reset, active-high
//   cg_enable_i    in   CSR bit, 0 = gating disallowed
//   busy_i         in   accelerator core busy
//   wake_req_i     in   level wake request, held until acknowledged
//   wake_ack_o     out  clock running and settled (combinational off state)
//   clk_en_o       out  registered enable to the clock-gate cell
//   gated_o        out  registered status, core clock currently gated
//   stats_clr_i    in   clear gated-cycle counter    (NTT_INTT_PWM_CG_STATS_EN)
//   gated_cycles_o out  saturating gated-cycle count (NTT_INTT_PWM_CG_STATS_EN)
//
// Optional feature macro: NTT_INTT_PWM_CG_STATS_EN
// ---------------------------------------------------------------------------
module ntt_intt_pwm_clock_gate_ctrl
    import ntt_intt_pwm_cg_pkg::*;
#(
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
    parameter int CNT_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cg_enable_i,
    input  logic               busy_i,
    input  logic               wake_req_i,
    output logic               wake_ack_o,
    output logic               clk_en_o,
    output logic               gated_o
`ifdef NTT_INTT_PWM_CG_STATS_EN
    ,
    input  logic               stats_clr_i,
    output logic [STATS_W-1:0] gated_cycles_o
`endif
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    cg_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_en_q, clk_en_d;
    logic             gated_q, gated_d;
    logic             act;

    // State, shared counter and the registered gate outputs. The outputs are
    // taken from next-state so the gate enable changes on the same edge as
    // the state transition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            clk_en_q <= 1'b1;
            gated_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clk_en_q <= clk_en_d;
            gated_q  <= gated_d;
        end
    end

    // Next-state logic. One counter serves both as the idle run length in
    // RUN and the settle timer in WAKE; it is held at zero in GATED so each
    // phase starts counting from a clean value.
    always_comb begin
        act      = busy_i | wake_req_i | ~cg_enable_i;
        state_d  = state_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            RUN: begin
                // Activity wins over gating, even on the terminal count.
                if (act) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = GATED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GATED: begin
                cnt_d = '0;
                if (act) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                // Inputs are ignored here: once woken, the clock always
                // settles fully before the controller may gate again.
                if (cnt_q == WAKE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        clk_en_d = (state_d != GATED);
        gated_d  = (state_d == GATED);
    end

    assign clk_en_o = clk_en_q;
    assign gated_o  = gated_q;

    // The ack is masked by reset so that a request already pending in RUN
    // cannot see a spurious ack during the reset cycle.
    assign wake_ack_o = (state_q == RUN) & wake_req_i & ~rst_i;

`ifdef NTT_INTT_PWM_CG_STATS_EN
    logic [STATS_W-1:0] gated_cycles_q, gated_cycles_d;

    // Saturating count of cycles spent with gated_o high; clear wins over
    // increment.
    always_comb begin
        gated_cycles_d = gated_cycles_q;
        if (stats_clr_i) begin
            gated_cycles_d = '0;
        end else if (gated_q && !(&gated_cycles_q)) begin
            gated_cycles_d = gated_cycles_q + STATS_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gated_cycles_q <= '0;
        end else begin
            gated_cycles_q <= gated_cycles_d;
        end
    end

    assign gated_cycles_o = gated_cycles_q;
`endif

endmodule : ntt_intt_pwm_clock_gate_ctrl
